// File: rtl/aoc4_pkg.sv
// Shared parameters, types and row helpers for the aoc4 paper-roll accelerator.
package aoc4_pkg;

    localparam int MAX_COLS        = 140;
    localparam int BANK_DEPTH      = 140;
    localparam int TX_DATA_WIDTH   = 32;
    localparam int BANK_ADDR_WIDTH = 8;
    localparam int COL_ADDR_WIDTH  = 8;

    typedef struct packed {
        logic [BANK_ADDR_WIDTH-1:0] row_addr;
        logic [COL_ADDR_WIDTH-1:0]  col_addr;
        logic [TX_DATA_WIDTH-1:0]   partial_vec;
        logic                       write_en;
        logic                       read_en;
        logic                       staging;
    } tb_packet_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_READ,
        ST_LD_WRITE,
        ST_PRIME,
        ST_SWEEP
    } state_t;

    // Chunk bits shifted past MAX_COLS fall off the top of the row.
    function automatic logic [MAX_COLS-1:0] merge_row(
        input logic [MAX_COLS-1:0]       row,
        input logic [COL_ADDR_WIDTH-1:0] col,
        input logic [TX_DATA_WIDTH-1:0]  vec
    );
        logic [MAX_COLS-1:0] mask_v;
        logic [MAX_COLS-1:0] data_v;
        mask_v = {{(MAX_COLS-TX_DATA_WIDTH){1'b0}}, {TX_DATA_WIDTH{1'b1}}} << col;
        data_v = {{(MAX_COLS-TX_DATA_WIDTH){1'b0}}, vec} << col;
        return (row & ~mask_v) | data_v;
    endfunction

    function automatic logic [7:0] popcount(input logic [MAX_COLS-1:0] v);
        logic [7:0] cnt_v;
        cnt_v = 8'd0;
        for (int i = 0; i < MAX_COLS; i++) begin
            cnt_v = cnt_v + 8'(v[i]);
        end
        return cnt_v;
    endfunction

endpackage

// File: rtl/aoc4_if.sv
// Host load port of the aoc4 accelerator: packet in, busy/ack back.
interface aoc4_if;

    logic                 pad_en;
    aoc4_pkg::tb_packet_t tb_packet_in;
    logic                 mem_ack_out;
    logic                 mem_busy_out;

    modport master (
        output pad_en,
        output tb_packet_in,
        input  mem_ack_out,
        input  mem_busy_out
    );

    modport slave (
        input  pad_en,
        input  tb_packet_in,
        output mem_ack_out,
        output mem_busy_out
    );

endinterface

// File: rtl/aoc4_row_bank.sv
// Row-organised grid storage: one synchronous read port, one write port, cleared on reset.
module row_bank
    import aoc4_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic [BANK_ADDR_WIDTH-1:0] rd_addr,
    output logic [MAX_COLS-1:0]        rd_data,
    input  logic                       wr_en,
    input  logic [BANK_ADDR_WIDTH-1:0] wr_addr,
    input  logic [MAX_COLS-1:0]        wr_data
);

    logic [MAX_COLS-1:0] rows_r [BANK_DEPTH];
    logic [MAX_COLS-1:0] rd_data_r;

    // Row storage with whole-bank clear on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < BANK_DEPTH; i++) begin
                rows_r[i] <= '0;
            end
        end else if (wr_en && (wr_addr < BANK_ADDR_WIDTH'(BANK_DEPTH))) begin
            rows_r[wr_addr] <= wr_data;
        end
    end

    // Registered read; addresses past the bank read as an empty row.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_r <= '0;
        end else if (rd_addr < BANK_ADDR_WIDTH'(BANK_DEPTH)) begin
            rd_data_r <= rows_r[rd_addr];
        end else begin
            rd_data_r <= '0;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/aoc4_top.sv
// Paper-roll removal accelerator: host row loads, then in-place 3-row sweeps to a fixed point.
// Define AOC4_SINGLE_PASS_EN to stop after one pass (accessible-roll count only).
module aoc4_top
    import aoc4_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        run_in,
    aoc4_if.slave       host,
    output logic        done_out,
    output logic [31:0] updates_out
);

    state_t                     state_r, state_s;
    logic [BANK_ADDR_WIDTH-1:0] row_r;
    logic [COL_ADDR_WIDTH-1:0]  col_r;
    logic [TX_DATA_WIDTH-1:0]   vec_r;
    logic                       busy_r, ack_r, done_r, any_r;
    logic [31:0]                upd_r;
    logic [BANK_ADDR_WIDTH-1:0] idx_r;
    logic [MAX_COLS-1:0]        prev_r, cur_r;

    logic [BANK_ADDR_WIDTH-1:0] rd_addr_s, wr_addr_s;
    logic [MAX_COLS-1:0]        rd_data_s, wr_data_s, next_row_s, removed_s, kept_s, prev_next_s;
    logic                       wr_en_s, accept_s, last_s, finish_s;
    logic [7:0]                 pop_s;
    logic                       rsvd_unused_s;

    assign accept_s      = host.pad_en && host.tb_packet_in.write_en;
    assign rsvd_unused_s = host.tb_packet_in.read_en ^ host.tb_packet_in.staging;
    assign last_s        = (idx_r == BANK_ADDR_WIDTH'(BANK_DEPTH));
    assign next_row_s    = last_s ? '0 : rd_data_s;
    assign kept_s        = cur_r & ~removed_s;
    assign pop_s         = popcount(removed_s);

`ifdef AOC4_SINGLE_PASS_EN
    // One pass judged against the original grid: prev stays unmodified.
    assign prev_next_s = cur_r;
    assign finish_s    = 1'b1;
`else
    assign prev_next_s = kept_s;
    assign finish_s    = !(any_r || (pop_s != 8'd0));
`endif

    row_bank u_bank (
        .clock   (clock),
        .reset   (reset),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s),
        .wr_en   (wr_en_s),
        .wr_addr (wr_addr_s),
        .wr_data (wr_data_s)
    );

    // Neighbour count per column; the window is zero-padded one column each side.
    always_comb begin
        logic [MAX_COLS+1:0] p_v, c_v, n_v;
        logic [3:0]          cnt_v;
        p_v       = {1'b0, prev_r, 1'b0};
        c_v       = {1'b0, cur_r, 1'b0};
        n_v       = {1'b0, next_row_s, 1'b0};
        removed_s = '0;
        for (int c = 0; c < MAX_COLS; c++) begin
            cnt_v = 4'(p_v[c]) + 4'(p_v[c+1]) + 4'(p_v[c+2]) + 4'(c_v[c]) + 4'(c_v[c+2])
                  + 4'(n_v[c]) + 4'(n_v[c+1]) + 4'(n_v[c+2]);
            removed_s[c] = c_v[c+1] && (cnt_v < 4'd4);
        end
    end

    // Bank port steering: load read-modify-write, or sweep read-ahead plus write-back.
    always_comb begin
        rd_addr_s = '0;
        wr_en_s   = 1'b0;
        wr_addr_s = '0;
        wr_data_s = '0;
        case (state_r)
            ST_LD_READ: rd_addr_s = row_r;
            ST_LD_WRITE: begin
                wr_en_s   = 1'b1;
                wr_addr_s = row_r;
                wr_data_s = merge_row(rd_data_s, col_r, vec_r);
            end
            ST_SWEEP: begin
                rd_addr_s = idx_r + BANK_ADDR_WIDTH'(1);
                wr_en_s   = (idx_r != '0);
                wr_addr_s = idx_r - BANK_ADDR_WIDTH'(1);
                wr_data_s = kept_s;
            end
            default: rd_addr_s = '0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run_in) begin
                    state_s = ST_PRIME;
                end else if (accept_s) begin
                    state_s = ST_LD_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LD_READ:  state_s = ST_LD_WRITE;
            ST_LD_WRITE: state_s = ST_IDLE;
            ST_PRIME:    state_s = ST_SWEEP;
            ST_SWEEP: begin
                if (last_s) begin
                    state_s = finish_s ? ST_IDLE : ST_PRIME;
                end else begin
                    state_s = ST_SWEEP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register, load capture, handshake flags and sweep window.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            row_r   <= '0;
            col_r   <= '0;
            vec_r   <= '0;
            busy_r  <= 1'b0;
            ack_r   <= 1'b0;
            done_r  <= 1'b0;
            any_r   <= 1'b0;
            upd_r   <= 32'd0;
            idx_r   <= '0;
            prev_r  <= '0;
            cur_r   <= '0;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_IDLE: begin
                    if (run_in) begin
                        upd_r  <= 32'd0;
                        done_r <= 1'b0;
                    end else if (accept_s) begin
                        row_r  <= host.tb_packet_in.row_addr;
                        col_r  <= host.tb_packet_in.col_addr;
                        vec_r  <= host.tb_packet_in.partial_vec;
                        busy_r <= 1'b1;
                    end
                end
                ST_LD_READ: ack_r <= 1'b1;
                ST_LD_WRITE: begin
                    ack_r  <= 1'b0;
                    busy_r <= 1'b0;
                end
                ST_PRIME: begin
                    idx_r  <= '0;
                    prev_r <= '0;
                    cur_r  <= '0;
                    any_r  <= 1'b0;
                end
                ST_SWEEP: begin
                    idx_r  <= idx_r + BANK_ADDR_WIDTH'(1);
                    prev_r <= prev_next_s;
                    cur_r  <= next_row_s;
                    any_r  <= any_r || (pop_s != 8'd0);
                    upd_r  <= upd_r + 32'(pop_s);
                    if (last_s && finish_s) begin
                        done_r <= 1'b1;
                    end
                end
                default: idx_r <= idx_r;
            endcase
        end
    end

    assign host.mem_ack_out  = ack_r;
    assign host.mem_busy_out = busy_r;
    assign done_out          = done_r;
    assign updates_out       = upd_r;

endmodule

// File: tb/tb_aoc4_top.sv
// Directed bench for aoc4_top against a whole-grid behavioural model of the removal puzzle.
module tb_aoc4_top;
    import aoc4_pkg::*;

`ifdef AOC4_SINGLE_PASS_EN
    localparam bit SINGLE = 1'b1;
`else
    localparam bit SINGLE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run_in = 1'b0;
    logic        done_out;
    logic [31:0] updates_out;

    aoc4_if bus();

    aoc4_top dut (
        .clock       (clock),
        .reset       (reset),
        .run_in      (run_in),
        .host        (bus),
        .done_out    (done_out),
        .updates_out (updates_out)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_miss = 0;

    logic        exp_busy = 1'b0, exp_ack = 1'b0, exp_done = 1'b0;
    logic [31:0] exp_upd = 32'd0;
    bit          chk_en = 1'b0, chk_done = 1'b0, chk_upd = 1'b0;

    bit g      [BANK_DEPTH][MAX_COLS];
    bit kill_m [BANK_DEPTH][MAX_COLS];

    string grid10 [10] = '{
        "..@@.@@@@.", "@@@.@.@@.@", "@@@@@.@.@@", "@.@@@@..@.", "@@.@@@@.@@",
        ".@@@@@@@.@", ".@.@.@.@@@", "@.@@@.@@@@", ".@@@@@@@@.", "@.@.@@@.@."
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("mem_busy_out", 32'(bus.mem_busy_out), 32'(exp_busy));
            check("mem_ack_out", 32'(bus.mem_ack_out), 32'(exp_ack));
            if (chk_done) check("done_out", 32'(done_out), 32'(exp_done));
            if (chk_upd) check("updates_out", updates_out, exp_upd);
        end
    end

    function automatic int occupied(int r, int c);
        if (r < 0 || r >= BANK_DEPTH || c < 0 || c >= MAX_COLS) return 0;
        return int'(g[r][c]);
    endfunction

    // Parallel-update passes over the whole grid until nothing is removed.
    task automatic model_run(output int removed, output int passes);
        int n;
        removed = 0;
        passes = 0;
        do begin
            n = 0;
            for (int r = 0; r < BANK_DEPTH; r++) begin
                for (int c = 0; c < MAX_COLS; c++) begin
                    kill_m[r][c] = 1'b0;
                    if (g[r][c]) begin
                        int k;
                        k = 0;
                        for (int dr = -1; dr <= 1; dr++)
                            for (int dc = -1; dc <= 1; dc++)
                                if (dr != 0 || dc != 0) k += occupied(r + dr, c + dc);
                        if (k < 4) begin
                            kill_m[r][c] = 1'b1;
                            n++;
                        end
                    end
                end
            end
            for (int r = 0; r < BANK_DEPTH; r++)
                for (int c = 0; c < MAX_COLS; c++)
                    if (kill_m[r][c]) g[r][c] = 1'b0;
            removed += n;
            passes++;
        end while (n != 0 && !SINGLE);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.pad_en = 1'b0;
        bus.tb_packet_in = '0;
        run_in = 1'b0;
        @(posedge clock); #1;
        exp_busy = 1'b0; exp_ack = 1'b0; exp_done = 1'b0; exp_upd = 32'd0;
        chk_en = 1'b1; chk_done = 1'b1; chk_upd = 1'b1;
        for (int r = 0; r < BANK_DEPTH; r++)
            for (int c = 0; c < MAX_COLS; c++) g[r][c] = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // pad_en is left high afterwards so a following load is back-to-back.
    task automatic load(input int row, input int col, input logic [31:0] v);
        bus.pad_en = 1'b1;
        bus.tb_packet_in.row_addr = 8'(row);
        bus.tb_packet_in.col_addr = 8'(col);
        bus.tb_packet_in.partial_vec = v;
        bus.tb_packet_in.write_en = 1'b1;
        bus.tb_packet_in.read_en = v[0];
        bus.tb_packet_in.staging = v[1];
        @(posedge clock); #1;
        exp_busy = 1'b1; exp_ack = 1'b0;
        @(posedge clock); #1;
        exp_ack = 1'b1;
        @(posedge clock); #1;
        exp_busy = 1'b0; exp_ack = 1'b0;
        for (int j = 0; j < TX_DATA_WIDTH; j++)
            if (col + j < MAX_COLS) g[row][col + j] = v[j];
    endtask

    task automatic port_idle();
        bus.pad_en = 1'b0;
        bus.tb_packet_in.write_en = 1'b0;
    endtask

    task automatic load_grid10();
        for (int r = 0; r < 10; r++) begin
            logic [31:0] v;
            v = 32'd0;
            for (int j = 0; j < 10; j++) v[j] = (grid10[r][j] == 8'h40);
            load(r, 0, v);
        end
        port_idle();
    endtask

    task automatic run_case(input string name, input int pin, input bit disturb, output int cyc);
        int rem, passes, bound;
        model_run(rem, passes);
        check({name, " model"}, 32'(rem), 32'(pin));
        bound = (passes + 2) * (BANK_DEPTH + 4) + 20;
        run_in = 1'b1;
        @(posedge clock); #1;
        run_in = 1'b0;
        exp_done = 1'b0; exp_upd = 32'd0; chk_done = 1'b1; chk_upd = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk_upd = 1'b0; chk_done = 1'b0;
        if (disturb) begin
            bus.pad_en = 1'b1;
            bus.tb_packet_in.row_addr = 8'd60;
            bus.tb_packet_in.col_addr = 8'd0;
            bus.tb_packet_in.partial_vec = 32'hFFFF_FFFF;
            bus.tb_packet_in.write_en = 1'b1;
            run_in = 1'b1;
            @(posedge clock); #1;
            run_in = 1'b0;
            port_idle();
        end
        cyc = 0;
        while (!done_out && cyc < bound) begin
            @(posedge clock); #1;
            cyc++;
        end
        check({name, " done seen"}, 32'(done_out), 32'd1);
        check({name, " updates"}, updates_out, 32'(rem));
        exp_done = 1'b1; exp_upd = 32'(rem); chk_done = 1'b1; chk_upd = 1'b1;
        repeat (3) @(posedge clock);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        bus.pad_en = 1'b0;
        bus.tb_packet_in = '0;
        do_reset();
        check("reset done_out", 32'(done_out), 32'd0);
        check("reset updates_out", updates_out, 32'd0);

        load(0, 0, 32'hFFFF_FFFF);
        port_idle();
        @(posedge clock); #1;
        run_case("row0 line", 32, 1'b0, cyc);

        do_reset();
        load(0, 128, 32'hFFFF_FFFF);
        load(0, 0, 32'h0000_0000);
        port_idle();
        run_case("chunk boundary", 12, 1'b0, cyc);

        do_reset();
        run_case("empty bank", 0, 1'b0, cyc);
        check("empty latency ok", 32'(cyc <= 2 * BANK_DEPTH + 10), 32'd1);

        do_reset();
        load(70, 100, 32'h0000_0001);
        load(139, 128, 32'h0000_0800);
        port_idle();
        run_case("single rolls", 2, 1'b0, cyc);

        do_reset();
        for (int r = 0; r < 3; r++) load(r, 0, 32'h0000_0007);
        port_idle();
        run_case("3x3 block", SINGLE ? 4 : 9, 1'b0, cyc);

        do_reset();
        load_grid10();
        run_case("10x10 example", SINGLE ? 13 : 43, 1'b1, cyc);

        do_reset();
        load_grid10();
        chk_done = 1'b0; chk_upd = 1'b0;
        run_in = 1'b1;
        @(posedge clock); #1;
        run_in = 1'b0;
        repeat (60) @(posedge clock);
        #1;
        do_reset();
        check("midrun reset done_out", 32'(done_out), 32'd0);
        check("midrun reset updates_out", updates_out, 32'd0);
        run_case("after reset", 0, 1'b0, cyc);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
